// File: rtl/awmc_actuator_drv.sv
// Washer actuator driver: turns wash-controller stage codes into dead-timed valve,
// pump and motor commands, with door-lock hold, end-of-cycle buzzer and sticky fault.
module awmc_actuator_drv #(
   parameter int DEAD_CYC  = 2,
   parameter int RUN_CYC   = 4,
   parameter int DWELL_CYC = 2,
   parameter int LOCK_HOLD = 3,
   parameter int BUZZ_CYC  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] stage,
   input  logic       done,
   output logic       fill_valve,
   output logic       drain_pump,
   output logic       motor_en,
   output logic       motor_dir,
   output logic       motor_fast,
   output logic       door_lock,
   output logic       buzzer,
   output logic       fault
);

   localparam int MAX_A   = (DEAD_CYC > RUN_CYC) ? DEAD_CYC : RUN_CYC;
   localparam int MAX_B   = (DWELL_CYC > LOCK_HOLD) ? DWELL_CYC : LOCK_HOLD;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_ALL = (MAX_C > BUZZ_CYC) ? MAX_C : BUZZ_CYC;
   localparam int CW      = (MAX_ALL < 2) ? 1 : $clog2(MAX_ALL);

   localparam logic [CW-1:0] ZERO     = CW'(0);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] DEAD_LD  = (DEAD_CYC  > 1) ? CW'(DEAD_CYC  - 1) : ZERO;
   localparam logic [CW-1:0] RUN_LD   = (RUN_CYC   > 1) ? CW'(RUN_CYC   - 1) : ZERO;
   localparam logic [CW-1:0] DWELL_LD = (DWELL_CYC > 1) ? CW'(DWELL_CYC - 1) : ZERO;
   localparam logic [CW-1:0] LOCK_LD  = (LOCK_HOLD > 1) ? CW'(LOCK_HOLD - 1) : ZERO;
   localparam logic [CW-1:0] BUZZ_LD  = (BUZZ_CYC  > 1) ? CW'(BUZZ_CYC  - 1) : ZERO;
   localparam logic          HOLD_EN  = (LOCK_HOLD > 0) ? 1'b1 : 1'b0;
   localparam logic          BUZZ_EN  = (BUZZ_CYC  > 0) ? 1'b1 : 1'b0;

   localparam logic [2:0] STG_FILL  = 3'b000;
   localparam logic [2:0] STG_WASH  = 3'b001;
   localparam logic [2:0] STG_RINSE = 3'b010;
   localparam logic [2:0] STG_DRAIN = 3'b011;
   localparam logic [2:0] STG_SPIN  = 3'b100;
   localparam logic [2:0] STG_IDLE  = 3'b111;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEAD = 2'd1, S_ACTIVE = 2'd2} state_t;
   typedef enum logic {SUB_RUN = 1'b0, SUB_DWELL = 1'b1} sub_t;

   state_t        r_state, w_state_nxt;
   sub_t          r_sub, w_sub_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [CW-1:0] r_lock_cnt, w_lock_cnt_nxt;
   logic [CW-1:0] r_buzz_cnt, w_buzz_cnt_nxt;
   logic          r_dir, w_dir_nxt;
   logic          r_door, w_door_nxt;
   logic          r_buzz, w_buzz_nxt;
   logic          r_fault;
   logic [2:0]    r_stage_q;
   logic          r_done_q;
   logic          r_fill, r_drain, r_men, r_mdir, r_mfast;
   logic          w_fill_nxt, w_drain_nxt, w_men_nxt, w_mdir_nxt, w_mfast_nxt;

   logic w_change, w_invalid, w_active_code, w_block, w_agitate, w_rise;

   assign w_change      = (stage != r_stage_q);
   assign w_invalid     = (stage == 3'b101) || (stage == 3'b110);
   assign w_active_code = (stage <= STG_SPIN);
   assign w_block       = w_invalid || r_fault;
   assign w_agitate     = (stage == STG_WASH) || (stage == STG_RINSE);
   assign w_rise        = done & ~r_done_q;

   // Stage sequencing: dead time, agitation timing and door-lock release countdown
   always_comb begin
      w_state_nxt    = r_state;
      w_sub_nxt      = r_sub;
      w_cnt_nxt      = r_cnt;
      w_dir_nxt      = r_dir;
      w_door_nxt     = r_door;
      w_lock_cnt_nxt = r_lock_cnt;
      case (r_state)
         S_IDLE: begin
            if (!w_block && w_change && w_active_code) begin
               w_state_nxt    = S_DEAD;
               w_cnt_nxt      = DEAD_LD;
               w_door_nxt     = 1'b1;
               w_lock_cnt_nxt = ZERO;
            end else if (r_door && (r_lock_cnt != ZERO)) begin
               w_lock_cnt_nxt = r_lock_cnt - ONE;
            end else begin
               w_door_nxt     = 1'b0;
               w_lock_cnt_nxt = ZERO;
            end
         end
         S_DEAD, S_ACTIVE: begin
            if (w_block || (w_change && !w_active_code)) begin
               w_state_nxt    = S_IDLE;
               w_cnt_nxt      = ZERO;
               w_door_nxt     = HOLD_EN;
               w_lock_cnt_nxt = LOCK_LD;
            end else if (w_change) begin
               w_state_nxt = S_DEAD;
               w_cnt_nxt   = DEAD_LD;
               w_door_nxt  = 1'b1;
            end else if (r_state == S_DEAD) begin
               if (r_cnt == ZERO) begin
                  w_state_nxt = S_ACTIVE;
                  w_sub_nxt   = SUB_RUN;
                  w_cnt_nxt   = RUN_LD;
                  w_dir_nxt   = 1'b0;
               end else begin
                  w_cnt_nxt = r_cnt - ONE;
               end
            end else if (w_agitate) begin
               // direction flips only when a dwell ends, so a dwell keeps the old direction
               if (r_cnt != ZERO) begin
                  w_cnt_nxt = r_cnt - ONE;
               end else if (r_sub == SUB_RUN) begin
                  w_sub_nxt = SUB_DWELL;
                  w_cnt_nxt = DWELL_LD;
               end else begin
                  w_sub_nxt = SUB_RUN;
                  w_cnt_nxt = RUN_LD;
                  w_dir_nxt = ~r_dir;
               end
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = ZERO;
            w_door_nxt     = 1'b0;
            w_lock_cnt_nxt = ZERO;
         end
      endcase
   end

   // Actuator commands for the upcoming cycle, decoded from the next state
   always_comb begin
      w_fill_nxt  = 1'b0;
      w_drain_nxt = 1'b0;
      w_men_nxt   = 1'b0;
      w_mdir_nxt  = 1'b0;
      w_mfast_nxt = 1'b0;
      if (w_state_nxt == S_ACTIVE) begin
         case (stage)
            STG_FILL:  w_fill_nxt = 1'b1;
            STG_WASH, STG_RINSE: begin
               w_men_nxt  = (w_sub_nxt == SUB_RUN);
               w_mdir_nxt = w_dir_nxt;
            end
            STG_DRAIN: w_drain_nxt = 1'b1;
            STG_SPIN: begin
               w_drain_nxt = 1'b1;
               w_men_nxt   = 1'b1;
               w_mfast_nxt = 1'b1;
            end
            default: w_fill_nxt = 1'b0;
         endcase
      end else begin
         w_fill_nxt = 1'b0;
      end
   end

   // Buzzer pulse; a fresh done edge restarts the count
   always_comb begin
      if (w_rise) begin
         w_buzz_nxt     = BUZZ_EN;
         w_buzz_cnt_nxt = BUZZ_LD;
      end else if (r_buzz && (r_buzz_cnt != ZERO)) begin
         w_buzz_nxt     = 1'b1;
         w_buzz_cnt_nxt = r_buzz_cnt - ONE;
      end else begin
         w_buzz_nxt     = 1'b0;
         w_buzz_cnt_nxt = ZERO;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sub      <= SUB_RUN;
         r_cnt      <= ZERO;
         r_lock_cnt <= ZERO;
         r_buzz_cnt <= ZERO;
         r_dir      <= 1'b0;
         r_door     <= 1'b0;
         r_buzz     <= 1'b0;
         r_fault    <= 1'b0;
         r_stage_q  <= STG_IDLE;
         r_done_q   <= 1'b0;
         r_fill     <= 1'b0;
         r_drain    <= 1'b0;
         r_men      <= 1'b0;
         r_mdir     <= 1'b0;
         r_mfast    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sub      <= w_sub_nxt;
         r_cnt      <= w_cnt_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_buzz_cnt <= w_buzz_cnt_nxt;
         r_dir      <= w_dir_nxt;
         r_door     <= w_door_nxt;
         r_buzz     <= w_buzz_nxt;
         r_fault    <= r_fault | w_invalid;
         r_stage_q  <= stage;
         r_done_q   <= done;
         r_fill     <= w_fill_nxt & ~w_drain_nxt & ~w_men_nxt;
         r_drain    <= w_drain_nxt;
         r_men      <= w_men_nxt;
         r_mdir     <= w_mdir_nxt;
         r_mfast    <= w_mfast_nxt;
      end
   end

   assign fill_valve = r_fill;
   assign drain_pump = r_drain;
   assign motor_en   = r_men;
   assign motor_dir  = r_mdir;
   assign motor_fast = r_mfast;
   assign door_lock  = r_door;
   assign buzzer     = r_buzz;
   assign fault      = r_fault;

endmodule

// File: tb/tb_awmc_actuator_drv.sv
// Bench for awmc_actuator_drv: directed vector table, corner sequences, and random
// stimulus against a timeline-based reference model.
module tb_awmc_actuator_drv;

   localparam int DEAD_CYC  = 2;
   localparam int RUN_CYC   = 4;
   localparam int DWELL_CYC = 2;
   localparam int LOCK_HOLD = 3;
   localparam int BUZZ_CYC  = 5;
   localparam int NVEC      = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] stage;
   logic       done;
   logic       fill_valve, drain_pump, motor_en, motor_dir, motor_fast, door_lock, buzzer, fault;
   logic [7:0] outs;

   awmc_actuator_drv #(
      .DEAD_CYC(DEAD_CYC), .RUN_CYC(RUN_CYC), .DWELL_CYC(DWELL_CYC),
      .LOCK_HOLD(LOCK_HOLD), .BUZZ_CYC(BUZZ_CYC)
   ) dut (
      .clk(clk), .reset(reset), .stage(stage), .done(done),
      .fill_valve(fill_valve), .drain_pump(drain_pump), .motor_en(motor_en),
      .motor_dir(motor_dir), .motor_fast(motor_fast), .door_lock(door_lock),
      .buzzer(buzzer), .fault(fault)
   );

   always #5 clk = ~clk;

   // {fill, drain, motor_en, motor_dir, motor_fast, door_lock, buzzer, fault}
   assign outs = {fill_valve, drain_pump, motor_en, motor_dir, motor_fast, door_lock, buzzer, fault};

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: elapsed-time view of the washer
   int         m_mode;
   int         m_code;
   int         m_t;
   int         m_s;
   int         m_r;
   bit         m_locked;
   bit         m_fault;
   logic [2:0] m_prev;
   logic       m_prev_done;

   typedef struct packed {
      logic [2:0] st;
      logic       dn;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = 0; m_code = 0; m_t = 0; m_s = 0; m_r = 1000;
      m_locked = 1'b0; m_fault = 1'b0; m_prev = 3'b111; m_prev_done = 1'b0;
   endtask

   task automatic model_edge(input logic [2:0] st, input logic dn);
      if (st == 3'd5 || st == 3'd6) m_fault = 1'b1;
      if (m_fault) begin
         if (m_mode == 1) begin m_mode = 0; m_s = 0; m_locked = 1'b1; end
         else m_s++;
      end else if (st != m_prev) begin
         if (st <= 3'd4) begin m_mode = 1; m_code = int'(st); m_t = 0; end
         else if (m_mode == 1) begin m_mode = 0; m_s = 0; m_locked = 1'b1; end
         else m_s++;
      end else if (m_mode == 1) m_t++;
      else m_s++;
      m_prev = st;
      if (dn && !m_prev_done) m_r = 0;
      else if (m_r < 1000) m_r++;
      m_prev_done = dn;
   endtask

   function automatic logic [7:0] model_out();
      logic f, d, me, md, mf, dl, bz;
      int a, ph;
      f = 1'b0; d = 1'b0; me = 1'b0; md = 1'b0; mf = 1'b0;
      if (m_mode == 1 && m_t >= DEAD_CYC) begin
         a = m_t - DEAD_CYC;
         case (m_code)
            0: f = 1'b1;
            1, 2: begin
               ph = a % (RUN_CYC + DWELL_CYC);
               me = (ph < RUN_CYC);
               md = ((a / (RUN_CYC + DWELL_CYC)) % 2) == 1;
            end
            3: d = 1'b1;
            4: begin d = 1'b1; me = 1'b1; mf = 1'b1; end
            default: f = 1'b0;
         endcase
      end
      dl = (m_mode == 1) || (m_locked && m_s < LOCK_HOLD);
      bz = (m_r < BUZZ_CYC);
      return {f, d, me, md, mf, dl, bz, m_fault};
   endfunction

   task automatic step(input logic [2:0] st, input logic dn);
      stage = st;
      done  = dn;
      @(posedge clk);
      model_edge(st, dn);
      #1;
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      #2;
      chk(name, outs, 8'b0000_0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   logic [19:0] men_pat;
   logic [19:0] dir_pat;
   logic [2:0]  r_st;
   logic        r_dn;
   int          fault_age;
   int          pick;

   initial begin
      reset = 1'b1; stage = 3'b111; done = 1'b0;
      model_reset();
      // fill -> drain -> spin -> idle hold -> spin -> idle -> drain -> buzzer
      vecs[0]  = {3'b111, 1'b0, 8'b0000_0000};
      vecs[1]  = {3'b000, 1'b0, 8'b0000_0100};
      vecs[2]  = {3'b000, 1'b0, 8'b0000_0100};
      vecs[3]  = {3'b000, 1'b0, 8'b1000_0100};
      vecs[4]  = {3'b000, 1'b0, 8'b1000_0100};
      vecs[5]  = {3'b011, 1'b0, 8'b0000_0100};
      vecs[6]  = {3'b011, 1'b0, 8'b0000_0100};
      vecs[7]  = {3'b011, 1'b0, 8'b0100_0100};
      vecs[8]  = {3'b100, 1'b0, 8'b0000_0100};
      vecs[9]  = {3'b100, 1'b0, 8'b0000_0100};
      vecs[10] = {3'b100, 1'b0, 8'b0110_1100};
      vecs[11] = {3'b100, 1'b0, 8'b0110_1100};
      vecs[12] = {3'b111, 1'b0, 8'b0000_0100};
      vecs[13] = {3'b111, 1'b0, 8'b0000_0100};
      vecs[14] = {3'b111, 1'b0, 8'b0000_0100};
      vecs[15] = {3'b111, 1'b0, 8'b0000_0000};
      vecs[16] = {3'b100, 1'b0, 8'b0000_0100};
      vecs[17] = {3'b100, 1'b0, 8'b0000_0100};
      vecs[18] = {3'b100, 1'b0, 8'b0110_1100};
      vecs[19] = {3'b111, 1'b0, 8'b0000_0100};
      vecs[20] = {3'b011, 1'b0, 8'b0000_0100};
      vecs[21] = {3'b011, 1'b0, 8'b0000_0100};
      vecs[22] = {3'b011, 1'b0, 8'b0100_0100};
      vecs[23] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[24] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[25] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[26] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[27] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[28] = {3'b011, 1'b1, 8'b0100_0100};
      vecs[29] = {3'b011, 1'b0, 8'b0100_0100};
      vecs[30] = {3'b011, 1'b1, 8'b0100_0110};
      vecs[31] = {3'b111, 1'b0, 8'b0000_0110};

      #2;
      chk("reset_state", outs, 8'b0000_0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].st, vecs[i].dn);
         chk($sformatf("vec%0d", i), outs, vecs[i].exp);
      end

      // wash agitation pattern
      do_reset("reset_before_wash");
      men_pat = 20'b1111_0011_1100_1111_0011;
      dir_pat = 20'b0000_0011_1111_0000_0011;
      step(3'b001, 1'b0); chk("wash_dead0", outs, 8'b0000_0100);
      step(3'b001, 1'b0); chk("wash_dead1", outs, 8'b0000_0100);
      for (int k = 0; k < 20; k++) begin
         step(3'b001, 1'b0);
         chk($sformatf("wash%0d", k), outs,
             {1'b0, 1'b0, men_pat[19-k], dir_pat[19-k], 1'b0, 1'b1, 1'b0, 1'b0});
      end

      // sticky fault
      do_reset("reset_before_fault");
      step(3'b101, 1'b0); chk("fault_set", outs, 8'b0000_0001);
      for (int k = 0; k < 4; k++) begin
         step(3'b000, 1'b0);
         chk($sformatf("fault_hold%0d", k), outs, 8'b0000_0001);
      end
      do_reset("fault_reset_clears");
      step(3'b111, 1'b0); chk("post_fault_idle", outs, 8'b0000_0000);
      step(3'b000, 1'b0); chk("post_fault_lock", outs, 8'b0000_0100);

      // mid-operation reset drops everything at once
      step(3'b000, 1'b0);
      step(3'b000, 1'b0); chk("fill_before_reset", outs, 8'b1000_0100);
      do_reset("reset_midop");

      // randomized stimulus against the reference model
      r_st = 3'b111; r_dn = 1'b0; fault_age = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 2) r_st = (pick == 0) ? 3'b101 : 3'b110;
            else if (pick < 22) r_st = 3'b111;
            else r_st = 3'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 5) == 0) r_dn = ~r_dn;
         step(r_st, r_dn);
         chk("rand", outs, model_out());
         if (m_fault) fault_age++;
         if (fault_age > 15 || $urandom_range(0, 399) == 0) begin
            do_reset("rand_reset");
            fault_age = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/awmc_actuator_drv.md
AWMC_ACTUATOR_DRV -- requirements
Module: awmc_actuator_drv

Interface
REQ-001 SHALL have parameter DEAD_CYC, default 2: all-actuators-off cycles on every stage change.
REQ-002 SHALL have parameter RUN_CYC, default 4: agitation motor-on cycles per half-cycle.
REQ-003 SHALL have parameter DWELL_CYC, default 2: agitation motor-off cycles between direction reversals.
REQ-004 SHALL have parameter LOCK_HOLD, default 3: door_lock hold cycles after leaving active stage.
REQ-005 SHALL have parameter BUZZ_CYC, default 5: buzzer pulse length in cycles.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port stage, input, 3, from the wash controller. 000 fill, 001 wash, 010 rinse, 011 drain, 100 spin, 111 idle/paused, 101/110 invalid.
REQ-009 SHALL have port done, input, 1, cycle-complete level from the wash controller.
REQ-010 SHALL have outputs fill_valve, drain_pump, motor_en, motor_dir, motor_fast, door_lock, buzzer, fault; each 1 bit, all registered.

Function
REQ-011 SHALL register stage into stage_q every cycle; a change is stage != stage_q.
REQ-012 SHALL implement states IDLE, DEAD, ACTIVE, with sub-states RUN and DWELL inside ACTIVE for wash/rinse.
REQ-013 SHALL, on a change to a valid active code (000-100) from any state, enter DEAD with a counter loaded to DEAD_CYC-1.
- Outputs fill_valve, drain_pump, motor_en, motor_dir and motor_fast SHALL be 0 throughout DEAD.
REQ-014 SHALL decrement the DEAD counter each cycle and enter ACTIVE on the edge after the counter reaches 0.
- Actuators are therefore off for exactly DEAD_CYC cycles after the change edge.
REQ-015 SHALL restart DEAD, reloading the counter, if stage changes again while in DEAD.
REQ-016 ACTIVE fill SHALL drive fill_valve=1, all other actuators 0.
REQ-017 ACTIVE drain SHALL drive drain_pump=1, all other actuators 0.
REQ-018 ACTIVE spin SHALL drive drain_pump=1, motor_en=1, motor_fast=1, motor_dir=0, continuously.
REQ-019 ACTIVE wash/rinse SHALL agitate as a repeating sequence, until the stage changes:
- RUN: motor_en=1 for RUN_CYC cycles.
- DWELL: motor_en=0 for DWELL_CYC cycles.
- Toggle motor_dir.
- Direction on ACTIVE entry is 0.
- motor_fast is 0 throughout.
REQ-020 SHALL, on stage changing to 111 or to an invalid code, enter IDLE and clear all actuator outputs on that edge.
REQ-021 SHALL hold door_lock=1 while in DEAD or ACTIVE.
- After entering IDLE, door_lock SHALL remain 1 for LOCK_HOLD cycles, then go to 0.
REQ-022 SHALL keep door_lock=1 (no release glitch) if an active code returns during the LOCK_HOLD countdown; DEAD proceeds per REQ-013.
REQ-023 SHALL detect a done rising edge (done=1, done_q=0) and drive buzzer=1 for exactly BUZZ_CYC cycles.
- A further rising edge during the pulse SHALL restart the count.
REQ-024 SHALL set fault=1 (sticky) when an invalid stage code is sampled; in that cycle the block is treated as idle per REQ-020.
- While fault=1, active codes SHALL be ignored, with all actuators 0, until reset.
REQ-025 SHALL never assert fill_valve and drain_pump simultaneously, and never assert motor_en with fill_valve.

Reset
REQ-026 SHALL, on reset assertion (asynchronous), immediately force:
- Outputs: all outputs 0.
- State: IDLE.
- Registers: stage_q=111, done_q=0, all counters 0.
REQ-027 SHALL, on a mid-operation reset, drop all actuators and door_lock within the same cycle, with no LOCK_HOLD.
REQ-028 SHALL, after reset release, remain in IDLE until a valid active code differs from stage_q.

Verification
REQ-029 Bench: stage 111->000 at edge N -> actuators 0 at N, N+1; fill_valve=1 from N+2; door_lock=1 from N.
REQ-030 Bench: stage=001 held 20 cycles after DEAD -> motor_en pattern 1111 00 1111 00..., with motor_dir 0,0,1,1 per half-cycle.
REQ-031 Bench: stage 100 -> 111 -> all actuators 0 next edge; door_lock 1 for 3 cycles then 0.
REQ-032 Bench: stage 100 -> 111 -> 011 within 2 cycles -> door_lock never drops; drain_pump=1 after 2 dead cycles.
REQ-033 Bench: done 0->1 -> buzzer=1 for exactly 5 cycles; done held high -> no retrigger.
REQ-034 Bench: stage=101 -> fault=1, actuators 0; subsequent stage=000 -> still 0; reset -> fault=0.
